// File: rtl/apb_csr_bank.sv
// rtl/apb_csr_bank.sv - parametrised APB slave register bank with RO status regs and write pulses
module apb_csr_bank #(
  parameter int unsigned         ADDR_W      = 3,
  parameter int unsigned         DATA_W      = 16,
  parameter int unsigned         NUM_REGS    = 8,
  parameter int unsigned         WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = 8'h80
) (
  input  logic                         pclk,
  input  logic                         preset_n,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [DATA_W-1:0]            pwdata,
  output logic                         pready,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pslverr,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          reg_wr_pulse,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_status
);

  localparam int unsigned       SLOTS      = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);
  localparam logic [SLOTS-1:0]  RO_EXT     = SLOTS'(RO_MASK);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q;
  logic [3:0]          wait_cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   prdata_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pulse_q;
  logic [DATA_W-1:0]   rd_val [SLOTS];

  logic setup;
  logic mapped;
  logic err;

  // Read view over the full index space; unmapped slots read as zero.
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    if (i < NUM_REGS) begin : g_mapped
      assign rd_val[i] = RO_EXT[i] ? hw_status[i*DATA_W +: DATA_W] : regs_q[i];
      assign reg_q[i*DATA_W +: DATA_W] = RO_EXT[i] ? '0 : regs_q[i];
    end else begin : g_unmapped
      assign rd_val[i] = '0;
    end
  end

  assign setup        = psel & ~penable;
  assign mapped       = {1'b0, addr_q} < NUM_REGS_L;
  assign err          = ~mapped | (write_q & RO_EXT[addr_q]);
  assign pready       = (state_q == ACCESS) & psel & penable & (wait_cnt_q == 4'd0);
  assign pslverr      = pready & err;
  assign prdata       = prdata_q;
  assign reg_wr_pulse = pulse_q;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      prdata_q   <= '0;
      pulse_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      pulse_q <= '0;
      case (state_q)
        IDLE: begin
          if (setup) begin
            state_q    <= ACCESS;
            wait_cnt_q <= 4'(WAIT_STATES);
            addr_q     <= paddr;
            write_q    <= pwrite;
            wdata_q    <= pwdata;
            prdata_q   <= pwrite ? '0 : rd_val[paddr];
          end
        end
        ACCESS: begin
          // Master abort drops the transfer without committing anything.
          if (!psel) begin
            state_q <= IDLE;
          end else if (penable) begin
            if (wait_cnt_q != 4'd0) begin
              wait_cnt_q <= wait_cnt_q - 4'd1;
            end else begin
              state_q <= IDLE;
              for (int i = 0; i < NUM_REGS; i++) begin
                if (write_q && !err && addr_q == ADDR_W'(i)) begin
                  regs_q[i]  <= wdata_q;
                  pulse_q[i] <= 1'b1;
                end
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_csr_bank.sv
// tb/tb_apb_csr_bank.sv - directed self-checking bench for apb_csr_bank
module tb_apb_csr_bank;

  logic pclk = 1'b0;
  logic preset_n;

  logic         a_psel, a_penable, a_pwrite, a_pready, a_pslverr;
  logic [2:0]   a_paddr;
  logic [15:0]  a_pwdata, a_prdata;
  logic [127:0] a_reg_q, a_hw;
  logic [7:0]   a_pulse;

  logic         b_psel, b_penable, b_pwrite, b_pready, b_pslverr;
  logic [2:0]   b_paddr;
  logic [15:0]  b_pwdata, b_prdata;
  logic [95:0]  b_reg_q, b_hw;
  logic [5:0]   b_pulse;

  int checks   = 0;
  int failures = 0;

  logic [127:0] exp_a;
  logic [95:0]  exp_b;
  logic [15:0]  rd;
  logic         er;
  int           wt;

  always #5 pclk = ~pclk;

  apb_csr_bank dut_a (
    .pclk(pclk), .preset_n(preset_n), .paddr(a_paddr), .psel(a_psel), .penable(a_penable),
    .pwrite(a_pwrite), .pwdata(a_pwdata), .pready(a_pready), .prdata(a_prdata),
    .pslverr(a_pslverr), .reg_q(a_reg_q), .reg_wr_pulse(a_pulse), .hw_status(a_hw)
  );

  apb_csr_bank #(.ADDR_W(3), .DATA_W(16), .NUM_REGS(6), .WAIT_STATES(3), .RO_MASK(6'h20)) dut_b (
    .pclk(pclk), .preset_n(preset_n), .paddr(b_paddr), .psel(b_psel), .penable(b_penable),
    .pwrite(b_pwrite), .pwdata(b_pwdata), .pready(b_pready), .prdata(b_prdata),
    .pslverr(b_pslverr), .reg_q(b_reg_q), .reg_wr_pulse(b_pulse), .hw_status(b_hw)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int d, input logic s, input logic e, input logic w,
                     input logic [2:0] ad, input logic [15:0] wd);
    if (d == 0) begin
      a_psel = s; a_penable = e; a_pwrite = w; a_paddr = ad; a_pwdata = wd;
    end else begin
      b_psel = s; b_penable = e; b_pwrite = w; b_paddr = ad; b_pwdata = wd;
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? a_pready : b_pready;
  endfunction

  // Ends at the completion cycle, so a following xfer runs back to back.
  task automatic xfer(input int d, input logic w, input logic [2:0] ad, input logic [15:0] wd,
                      output logic [15:0] rdata, output logic err, output int waits);
    @(negedge pclk);
    drv(d, 1'b1, 1'b0, w, ad, wd);
    @(negedge pclk);
    drv(d, 1'b1, 1'b1, w, ad ^ 3'h5, ~wd);
    #1;
    waits = 0;
    while (!rdy(d) && waits < 40) begin
      @(negedge pclk);
      #1;
      waits++;
    end
    check("xfer_timeout", 128'(waits < 40), 128'd1);
    rdata = (d == 0) ? a_prdata : b_prdata;
    err   = (d == 0) ? a_pslverr : b_pslverr;
  endtask

  task automatic idle(input int d);
    @(negedge pclk);
    drv(d, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    preset_n = 1'b0;
    a_hw = '0;
    b_hw = '0;
    drv(0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    drv(1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    repeat (3) @(negedge pclk);
    #1;
    check("rst_pready", a_pready, 1'b0);
    check("rst_pslverr", a_pslverr, 1'b0);
    check("rst_prdata", a_prdata, 16'd0);
    check("rst_pulse", a_pulse, 8'd0);
    check("rst_reg_q_a", a_reg_q, 128'd0);
    check("rst_reg_q_b", b_reg_q, 96'd0);
    @(negedge pclk);
    preset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      xfer(0, 1'b0, 3'(i), 16'd0, rd, er, wt);
      check("t1_read_data", rd, 16'd0);
      check("t1_read_err", er, 1'b0);
      check("t1_pulse", a_pulse, 8'd0);
    end
    idle(0);

    xfer(0, 1'b1, 3'd2, 16'hA5A5, rd, er, wt);
    check("t2_wr_waits", wt, 0);
    check("t2_wr_err", er, 1'b0);
    idle(0);
    #1;
    check("t2_pulse_hi", a_pulse, 8'h04);
    @(negedge pclk);
    #1;
    check("t2_pulse_lo", a_pulse, 8'h00);
    exp_a = '0;
    exp_a[2*16 +: 16] = 16'hA5A5;
    check("t2_reg_q", a_reg_q, exp_a);
    xfer(0, 1'b0, 3'd2, 16'd0, rd, er, wt);
    check("t2_rd_data", rd, 16'hA5A5);
    idle(0);

    xfer(1, 1'b1, 3'd1, 16'h3C3C, rd, er, wt);
    check("t3_wr_waits", wt, 3);
    idle(1);
    #1;
    check("t3_pulse_b", b_pulse, 6'h02);
    @(negedge pclk);
    drv(1, 1'b1, 1'b0, 1'b0, 3'd1, 16'd0);
    @(negedge pclk);
    drv(1, 1'b1, 1'b1, 1'b0, 3'd4, 16'hFFFF);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("t3_pready_low", b_pready, 1'b0);
      check("t3_prdata_hold", b_prdata, 16'h3C3C);
      @(negedge pclk);
      #1;
    end
    check("t3_pready_high", b_pready, 1'b1);
    check("t3_prdata_done", b_prdata, 16'h3C3C);
    check("t3_pslverr", b_pslverr, 1'b0);
    idle(1);

    xfer(0, 1'b1, 3'd7, 16'hFFFF, rd, er, wt);
    check("t4_ro_err", er, 1'b1);
    idle(0);
    #1;
    check("t4_ro_pulse", a_pulse, 8'h00);
    check("t4_ro_reg_q", a_reg_q, exp_a);
    exp_b = '0;
    exp_b[1*16 +: 16] = 16'h3C3C;
    xfer(1, 1'b1, 3'd6, 16'h7777, rd, er, wt);
    check("t4_unmap_wr_err", er, 1'b1);
    idle(1);
    #1;
    check("t4_unmap_pulse", b_pulse, 6'h00);
    check("t4_unmap_reg_q", b_reg_q, exp_b);
    xfer(1, 1'b0, 3'd7, 16'd0, rd, er, wt);
    check("t4_unmap_rd_data", rd, 16'd0);
    check("t4_unmap_rd_err", er, 1'b1);
    idle(1);

    a_hw[7*16 +: 16] = 16'h1234;
    a_hw[2*16 +: 16] = 16'hDEAD;
    xfer(0, 1'b0, 3'd7, 16'd0, rd, er, wt);
    check("t5_ro_data", rd, 16'h1234);
    check("t5_ro_err", er, 1'b0);
    xfer(0, 1'b0, 3'd2, 16'd0, rd, er, wt);
    check("t5_rw_ignores_hw", rd, 16'hA5A5);
    check("t5_reg_q_ro_zero", a_reg_q, exp_a);

    xfer(0, 1'b1, 3'd3, 16'h0F0F, rd, er, wt);
    xfer(0, 1'b0, 3'd3, 16'd0, rd, er, wt);
    check("t6_b2b_rd", rd, 16'h0F0F);
    xfer(0, 1'b1, 3'd4, 16'h1111, rd, er, wt);
    xfer(0, 1'b1, 3'd5, 16'h2222, rd, er, wt);
    idle(0);
    @(negedge pclk);
    exp_a[3*16 +: 16] = 16'h0F0F;
    exp_a[4*16 +: 16] = 16'h1111;
    exp_a[5*16 +: 16] = 16'h2222;
    check("t6_b2b_reg_q", a_reg_q, exp_a);

    @(negedge pclk);
    drv(1, 1'b1, 1'b0, 1'b1, 3'd2, 16'hBEEF);
    @(negedge pclk);
    drv(1, 1'b1, 1'b1, 1'b1, 3'd2, 16'hBEEF);
    #1;
    check("t6_abort_pready", b_pready, 1'b0);
    @(negedge pclk);
    drv(1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    repeat (4) begin
      @(negedge pclk);
      #1;
      check("t6_abort_pulse", b_pulse, 6'h00);
    end
    check("t6_abort_reg_q", b_reg_q, exp_b);
    xfer(1, 1'b0, 3'd2, 16'd0, rd, er, wt);
    check("t6_after_abort_rd", rd, 16'd0);
    check("t6_after_abort_waits", wt, 3);
    idle(1);

    @(negedge pclk);
    drv(0, 1'b1, 1'b0, 1'b1, 3'd6, 16'h6666);
    @(negedge pclk);
    drv(0, 1'b1, 1'b1, 1'b1, 3'd6, 16'h6666);
    #1;
    check("t6_rst_pre_pready", a_pready, 1'b1);
    preset_n = 1'b0;
    #1;
    check("t6_rst_pready", a_pready, 1'b0);
    check("t6_rst_reg_q_a", a_reg_q, 128'd0);
    check("t6_rst_reg_q_b", b_reg_q, 96'd0);
    @(negedge pclk);
    drv(0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    preset_n = 1'b1;
    @(negedge pclk);
    #1;
    check("t6_rst_no_pulse", a_pulse, 8'h00);
    check("t6_rst_no_write", a_reg_q, 128'd0);
    xfer(0, 1'b0, 3'd6, 16'd0, rd, er, wt);
    check("t6_rst_rd6", rd, 16'd0);
    idle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
